// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the single register-file write port
// between the ALU writeback (A) and the memory-load writeback (B).
// The granted write is registered so it stays stable across the
// register file's negedge write strobe. Writes to $0 can be dropped,
// and committed writes are counted in a saturating counter.
//
// Handshake: a source transfers on a posedge where x_valid && x_ready.
// x_ready is combinational from the current inputs and the registered
// arbiter state. It is never high unless x_valid is high. a_ready and
// b_ready are mutually exclusive, and both are low during wb_stall or reset.
//
// Build option WB_ARB_RR_EN: when defined, arbitration is strict round-robin
// and the starvation counter is removed. When undefined (the default),
// A has fixed priority and B wins after losing STARVE_LIMIT cycles in a row.
module regfile_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter bit          DROP_R0      = 1'b1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_stall,
   input  logic             a_valid,
   input  logic [4:0]       a_dest,
   input  logic [31:0]      a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [4:0]       b_dest,
   input  logic [31:0]      b_data,
   output logic             b_ready,
   output logic             wwreg,
   output logic [4:0]       wdestReg,
   output logic [31:0]      wbData,
   output logic             wb_conflict,
   output logic [CNT_W-1:0] wb_count
);

   typedef enum logic {
      PRI_A = 1'b0,
      PRI_B = 1'b1
   } arb_state_e;

   arb_state_e       state_q, state_d;
   logic             wwreg_q, wwreg_d;
   logic [4:0]       wdest_q, wdest_d;
   logic [31:0]      wbdata_q, wbdata_d;
   logic             conflict_q, conflict_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             a_grant, b_grant;
   logic [4:0]       sel_dest;
   logic [31:0]      sel_data;

`ifndef WB_ARB_RR_EN
   localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);
   logic [3:0]       starve_q, starve_d;
`endif

   // Grant: the preferred source wins a tie; a lone valid source always wins.
   always_comb begin
      a_grant = 1'b0;
      b_grant = 1'b0;
      if (rst_n && !wb_stall) begin
         if (a_valid && b_valid) begin
            if (state_q == PRI_A) a_grant = 1'b1;
            else                  b_grant = 1'b1;
         end else if (a_valid) begin
            a_grant = 1'b1;
         end else if (b_valid) begin
            b_grant = 1'b1;
         end
      end
   end

   assign a_ready = a_grant;
   assign b_ready = b_grant;

   // Next arbiter state; wb_stall freezes both the state and the starve counter.
`ifndef WB_ARB_RR_EN
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      if (!wb_stall) begin
         if (state_q == PRI_A) begin
            if (b_valid && !b_grant) begin
               starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
            end else begin
               starve_d = 4'd0;
            end
            if (starve_d >= STARVE_LIM4) state_d = PRI_B;
         end else if (b_grant || !b_valid) begin
            state_d  = PRI_A;
            starve_d = 4'd0;
         end
      end
   end
`else
   always_comb begin
      state_d = state_q;
      if (!wb_stall) begin
         if (a_grant)      state_d = PRI_B;
         else if (b_grant) state_d = PRI_A;
      end
   end
`endif

   // Write-port datapath: capture the granted write, drop $0, count commits.
   always_comb begin
      sel_dest   = a_grant ? a_dest : b_dest;
      sel_data   = a_grant ? a_data : b_data;
      wwreg_d    = 1'b0;
      wdest_d    = wdest_q;
      wbdata_d   = wbdata_q;
      count_d    = count_q;
      conflict_d = a_valid && b_valid && (a_dest == b_dest) && !wb_stall;
      if (a_grant || b_grant) begin
         wdest_d  = sel_dest;
         wbdata_d = sel_data;
         wwreg_d  = !(DROP_R0 && (sel_dest == 5'd0));
      end
      if (wwreg_d && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // All state registers, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= PRI_A;
         wwreg_q    <= 1'b0;
         wdest_q    <= 5'd0;
         wbdata_q   <= 32'd0;
         conflict_q <= 1'b0;
         count_q    <= '0;
`ifndef WB_ARB_RR_EN
         starve_q   <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         wwreg_q    <= wwreg_d;
         wdest_q    <= wdest_d;
         wbdata_q   <= wbdata_d;
         conflict_q <= conflict_d;
         count_q    <= count_d;
`ifndef WB_ARB_RR_EN
         starve_q   <= starve_d;
`endif
      end
   end

   assign wwreg       = wwreg_q;
   assign wdestReg    = wdest_q;
   assign wbData      = wbdata_q;
   assign wb_conflict = conflict_q;
   assign wb_count    = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: table of per-cycle vectors
// {inputs, expected ready, expected registered outputs}, plus a
// mid-run reset sequence. A second instance with a 2-bit counter
// checks saturation of wb_count.
module tb_regfile_wb_arbiter;

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        av;
      logic [4:0]  ad;
      logic [31:0] adat;
      logic        bv;
      logic [4:0]  bd;
      logic [31:0] bdat;
      logic        ea;
      logic        eb;
      logic        eww;
      logic [4:0]  edest;
      logic [31:0] edat;
      logic        econf;
      int          ecnt;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n    = 1'b0;
   logic        wb_stall = 1'b0;
   logic        a_valid  = 1'b0;
   logic [4:0]  a_dest   = 5'd0;
   logic [31:0] a_data   = 32'd0;
   logic        b_valid  = 1'b0;
   logic [4:0]  b_dest   = 5'd0;
   logic [31:0] b_data   = 32'd0;

   logic        a_ready, b_ready, wwreg, wb_conflict;
   logic [4:0]  wdestReg;
   logic [31:0] wbData;
   logic [15:0] wb_count;

   logic        a_ready2, b_ready2, wwreg2, wb_conflict2;
   logic [4:0]  wdestReg2;
   logic [31:0] wbData2;
   logic [1:0]  wb_count2;

   regfile_wb_arbiter dut (
      .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
      .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
      .wwreg(wwreg), .wdestReg(wdestReg), .wbData(wbData),
      .wb_conflict(wb_conflict), .wb_count(wb_count)
   );

   regfile_wb_arbiter #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
      .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready2),
      .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready2),
      .wwreg(wwreg2), .wdestReg(wdestReg2), .wbData(wbData2),
      .wb_conflict(wb_conflict2), .wb_count(wb_count2)
   );

   // register file observed at the negedge write strobe
   logic [31:0] rf [32];
   initial for (int i = 0; i < 32; i++) rf[i] = 32'd0;
   always @(negedge clk) if (wwreg === 1'b1) rf[wdestReg] = wbData;

   int n_vec  = 0;
   int n_fail = 0;
   vec_t tbl[$];

   // generator state for the long arbitration run
   int          g_cnt;
   logic [4:0]  g_dest;
   logic [31:0] g_data;

   function automatic vec_t mk(logic r, logic s, logic av, logic [4:0] ad, logic [31:0] adat,
                               logic bv, logic [4:0] bd, logic [31:0] bdat,
                               logic ea, logic eb, logic eww, logic [4:0] edest,
                               logic [31:0] edat, logic econf, int ecnt);
      vec_t v;
      v.rst_n = r;  v.stall = s;
      v.av = av;    v.ad = ad;   v.adat = adat;
      v.bv = bv;    v.bd = bd;   v.bdat = bdat;
      v.ea = ea;    v.eb = eb;   v.eww = eww;
      v.edest = edest; v.edat = edat; v.econf = econf; v.ecnt = ecnt;
      return v;
   endfunction

   // pattern codes: 0 = A wins, 1 = B wins, 2 = stalled cycle (both valid throughout)
   task automatic gen(input int pat[$]);
      foreach (pat[i]) begin
         if (pat[i] == 2) begin
            tbl.push_back(mk(1, 1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2,
                             0, 0, 0, g_dest, g_data, 0, g_cnt));
         end else begin
            g_cnt++;
            g_dest = (pat[i] == 1) ? 5'd2 : 5'd1;
            g_data = (pat[i] == 1) ? 32'hB2 : 32'hA1;
            tbl.push_back(mk(1, 0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2,
                             pat[i] == 0, pat[i] == 1, 1, g_dest, g_data, 0, g_cnt));
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, n_vec, act, exp);
      end
   endtask

   // driver: inputs at negedge, ready checked before the edge, outputs 1 after it
   task automatic apply(input vec_t v);
      @(negedge clk);
      rst_n = v.rst_n; wb_stall = v.stall;
      a_valid = v.av; a_dest = v.ad; a_data = v.adat;
      b_valid = v.bv; b_dest = v.bd; b_data = v.bdat;
      #1;
      n_vec++;
      chk("a_ready", {31'd0, a_ready}, {31'd0, v.ea});
      chk("b_ready", {31'd0, b_ready}, {31'd0, v.eb});
      @(posedge clk);
      #1;
      chk("wwreg", {31'd0, wwreg}, {31'd0, v.eww});
      chk("wdestReg", {27'd0, wdestReg}, {27'd0, v.edest});
      chk("wbData", wbData, v.edat);
      chk("wb_conflict", {31'd0, wb_conflict}, {31'd0, v.econf});
      chk("wb_count", {16'd0, wb_count}, 32'(v.ecnt));
      chk("wb_count_sat", {30'd0, wb_count2}, (v.ecnt > 3) ? 32'd3 : 32'(v.ecnt));
   endtask

   initial begin
      int pat_run[$];
      int pat_post[$];
`ifndef WB_ARB_RR_EN
      pat_run  = '{0,0,0,0,1, 0,0,0,0,1, 0,0,2,2,2,0,0,1, 0};
      pat_post = '{0,0,0,0,1};
`else
      pat_run  = '{1,0,1,0,1, 0,1,0,1,0, 1,0,2,2,2,1,0,1, 0};
      pat_post = '{0,1};
`endif

      // reset held 2 cycles with A requesting
      tbl.push_back(mk(0,0, 1,5'd3,32'h11, 0,5'd0,32'd0, 0,0, 0,5'd0,32'd0, 0,0));
      tbl.push_back(mk(0,0, 1,5'd3,32'h11, 0,5'd0,32'd0, 0,0, 0,5'd0,32'd0, 0,0));
      // single A write
      tbl.push_back(mk(1,0, 1,5'd5,32'hDEADBEEF, 0,5'd0,32'd0, 1,0, 1,5'd5,32'hDEADBEEF, 0,1));
      // idle: wwreg drops, address/data hold
      tbl.push_back(mk(1,0, 0,5'd0,32'd0, 0,5'd0,32'd0, 0,0, 0,5'd5,32'hDEADBEEF, 0,1));
      // B write to $0 is accepted but dropped
      tbl.push_back(mk(1,0, 0,5'd0,32'd0, 1,5'd0,32'h1234, 0,1, 0,5'd0,32'h1234, 0,1));
      // B alone
      tbl.push_back(mk(1,0, 0,5'd0,32'd0, 1,5'd9,32'hCAFE, 0,1, 1,5'd9,32'hCAFE, 0,2));
      // same-dest conflict: A first, then pending B
      tbl.push_back(mk(1,0, 1,5'd7,32'd1, 1,5'd7,32'd2, 1,0, 1,5'd7,32'd1, 1,3));
      tbl.push_back(mk(1,0, 0,5'd0,32'd0, 1,5'd7,32'd2, 0,1, 1,5'd7,32'd2, 0,4));
      // A write to $0 dropped
      tbl.push_back(mk(1,0, 1,5'd0,32'h55, 0,5'd0,32'd0, 1,0, 0,5'd0,32'h55, 0,4));
      // both held high: starvation escape / round-robin, with a 3-cycle stall
      g_cnt = 4; g_dest = 5'd0; g_data = 32'h55;
      gen(pat_run);

      foreach (tbl[i]) apply(tbl[i]);

      // conflict ordering and $0 drop seen by the register file
      n_vec++;
      chk("rf7_last_write", rf[7], 32'd2);
      chk("rf0_untouched", rf[0], 32'd0);
      chk("rf5", rf[5], 32'hDEADBEEF);

      // mid-run reset with both requesting: outputs, counter and arbiter clear
      apply(mk(0,0, 1,5'd1,32'hA1, 1,5'd2,32'hB2, 0,0, 0,5'd0,32'd0, 0,0));
      apply(mk(0,0, 1,5'd1,32'hA1, 1,5'd2,32'hB2, 0,0, 0,5'd0,32'd0, 0,0));
      tbl.delete();
      g_cnt = 0; g_dest = 5'd0; g_data = 32'd0;
      gen(pat_post);
      foreach (tbl[i]) apply(tbl[i]);

      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
